dected_encoder_pipe: RTL and testbench
======================================

Name: dected_encoder_pipe

Overview:
- Parametrised, pipelined DEC-TED encoder: accepts DATA_W-bit words on a valid/ready stream and emits {parity, data} codewords two cycles later.
- The parity-check matrix is a flat parameter, so one block serves the 32-bit datapath and wider or narrower variants.
- Adds per-word error injection for decoder verification and an encoded-word counter.
- Sits between the register-file/memory write port and the storage array, ahead of the matching decoder.

Parameters:
- DATA_W, 32, data word width.
- PAR_W, 7, parity width.
- H_MASK, DECTED_H32_7 (package constant), PAR_W*DATA_W flat mask. Row r occupies bits [r*DATA_W +: DATA_W]. A 1 means the data bit feeds parity[r].
- CNT_W, 16, width of the encoded-word counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  data word.
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts codeword.
- out_code  out  DATA_W+PAR_W  codeword, {parity, data}, parity in the MSBs.
- inj_arm  in  1  one-cycle pulse; arms injection for the next accepted word.
- inj_mask  in  DATA_W+PAR_W  bits to flip, sampled when inj_arm=1.
- inj_pending  out  1  injection armed and not yet consumed.
- word_cnt  out  CNT_W  number of codewords delivered (out handshakes).

Behaviour:
- Reset (asynchronous, rst_n=0) forces out_valid=0, out_code=0, inj_pending=0, word_cnt=0 and clears all stage valids. in_ready is 1 once out of reset.
- Parity: parity[r] = XOR of in_data[i] over every i where H_MASK[r*DATA_W+i]=1.
- Pipeline: two register stages, latency exactly 2 cycles from input handshake to out_valid with out_ready held high.
  - Stage 1 registers the data plus per-row partial XORs over DATA_W/8-bit byte groups. Byte-group width is ceil(DATA_W/8); the last group is partial when DATA_W is not a multiple of 8.
  - Stage 2 reduces the partials, applies injection, and registers out_code.
- Handshake:
  - s2_en = !out_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en (combinational from out_ready; no bubble at full throughput).
- Throughput: one word per cycle when out_ready=1.
- Stall: out_code and out_valid are held stable while out_valid=1 and out_ready=0. Input words are never dropped or duplicated.
- Injection:
  - inj_arm=1 loads inj_mask into the armed register and sets inj_pending.
  - The next input handshake tags that word with the mask and clears inj_pending. Stage 2 XORs the mask onto the full codeword.
  - If inj_arm and an input handshake occur in the same cycle, the injection applies to that word and inj_pending stays 0.
  - A second inj_arm while pending overwrites the mask.
  - An all-zero mask is legal and has no effect.
- Counter: word_cnt increments on each out_valid&out_ready and wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: in-flight words and a pending injection are discarded with no partial output.
- Elaboration-time errors: DATA_W<1, PAR_W<1, or $bits(H_MASK) != PAR_W*DATA_W.

Decomposition:
- Package dected_pkg contains:
  - DECTED_H32_7 constant. Its rows are given here as bit lists of in_data feeding each parity bit:
    - p0: 0,1,2,3,4,5,6,7,14,19,22,24,30,31
    - p1: 4,7,8,9,10,11,12,13,14,15,18,21,24,29
    - p2: 3,11,16,17,18,19,20,21,22,23,26,27,29,30
    - p3: 2,6,10,13,15,16,24,25,26,27,28,29,30,31
    - p4: 1,2,5,7,9,12,15,20,21,22,23,25,26,28
    - p5: 0,5,6,8,12,13,14,16,17,18,19,20,28
    - p6: 0,1,3,4,8,9,10,11,17,23,25,27,31
  - default widths.
  - a codeword-width localparam helper.
- One sub-module: dected_parity_tree, a purely combinational masked XOR reduction of one row. It is instantiated PAR_W times per stage slice.

Test Plan:
- Reset with rst_n=0 mid-stream, in_data=0x1234_5678 in flight -> out_valid=0, word_cnt=0, inj_pending=0, and no stale word emitted after release.
- in_data=0x0000_0001, out_ready=1 -> out_code = {7'h61, 32'h0000_0001} exactly 2 cycles after the handshake.
- in_data=0xFFFF_FFFF then 0x0000_0000 back-to-back -> codewords {7'h60, FFFF_FFFF} then {7'h00, 0000_0000} on consecutive cycles, and word_cnt=2.
- out_ready=0 for 5 cycles during a 4-word burst -> out_code held stable, in_ready drops once both stages are full, all 4 words appear in order, word_cnt=4.
- inj_arm with inj_mask = bit 0 | bit 38, then send 0x0000_0001 -> out_code = {7'h21, 32'h0000_0000} and inj_pending returns to 0. The following word is unmodified.
- Preload word_cnt to 0xFFFF by driving 65535 words, then send 1 more -> word_cnt=0x0000.

Source files
------------

// File: rtl/dected_pkg.sv
// dected_pkg
//   Shared constants for the DEC-TED encoder family:
//     DECTED_H32_7   default 7x32 parity-check mask, row r at [r*32 +: 32]
//     DEF_*          default data / parity / counter widths
//     code_w()       codeword width helper (data + parity)
//     group_w()      width of one stage-1 partial-XOR byte group
package dected_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PAR_W  = 7;
  localparam int DEF_CNT_W  = 16;

  // Rows listed top-down from parity[6] to parity[0]; each 32-bit word marks
  // the data bits that feed that parity bit.
  localparam logic [DEF_PAR_W*DEF_DATA_W-1:0] DECTED_H32_7 = {
    32'h8A820F1B,  // p6: 0,1,3,4,8,9,10,11,17,23,25,27,31
    32'h101F7161,  // p5: 0,5,6,8,12,13,14,16,17,18,19,20,28
    32'h16F092A6,  // p4: 1,2,5,7,9,12,15,20,21,22,23,25,26,28
    32'hFF01A444,  // p3: 2,6,10,13,15,16,24..31
    32'h6CFF0808,  // p2: 3,11,16..23,26,27,29,30
    32'h2124FF90,  // p1: 4,7,8..15,18,21,24,29
    32'hC14840FF   // p0: 0..7,14,19,22,24,30,31
  };

  function automatic int code_w(input int data_w, input int par_w);
    return data_w + par_w;
  endfunction

  // ceil(data_w/8): eight groups for byte-multiple widths, last group
  // partial otherwise.
  function automatic int group_w(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/dected_parity_tree.sv
// dected_parity_tree
//   Purely combinational masked XOR reduction of one parity row slice.
//   Ports:
//     data   [W-1:0]  input bits
//     mask   [W-1:0]  1 = bit participates
//     parity          XOR of data bits selected by mask
module dected_parity_tree #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] mask,
  output logic         parity
);

  assign parity = ^(data & mask);

endmodule

// File: rtl/dected_encoder_pipe.sv
// dected_encoder_pipe
//   Two-stage pipelined DEC-TED encoder with per-word error injection.
//   Codeword layout is {parity, data}, parity in the MSBs.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     input stream handshake, in_data DATA_W bits
//     out_valid/out_ready   output stream handshake, out_code DATA_W+PAR_W
//     inj_arm, inj_mask     arm a bit-flip mask for the next accepted word
//     inj_pending           mask armed and not yet attached to a word
//     word_cnt              count of delivered codewords (wraps)
module dected_encoder_pipe
  import dected_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAR_W  = DEF_PAR_W,
  parameter     H_MASK = DECTED_H32_7,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W+PAR_W-1:0]     out_code,
  input  logic                        inj_arm,
  input  logic [DATA_W+PAR_W-1:0]     inj_mask,
  output logic                        inj_pending,
  output logic [CNT_W-1:0]            word_cnt
);

  localparam int CW = code_w(DATA_W, PAR_W);
  localparam int GW = group_w(DATA_W);
  localparam int NG = (DATA_W + GW - 1) / GW;
  // Data padded with zeros up to a whole number of groups so every group
  // slice is the same width; pad bits never contribute to parity.
  localparam int PW = NG * GW;

  // Elaboration-time parameter sanity.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("dected_encoder_pipe: DATA_W must be >= 1");
  end
  if (PAR_W < 1) begin : g_bad_par_w
    $error("dected_encoder_pipe: PAR_W must be >= 1");
  end
  if ($bits(H_MASK) != PAR_W * DATA_W) begin : g_bad_h_mask
    $error("dected_encoder_pipe: H_MASK width must equal PAR_W*DATA_W");
  end

  localparam logic [PAR_W*DATA_W-1:0] HM = H_MASK;

  // --------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_en;
  logic s1_en;
  logic in_fire;
  logic out_fire;

  assign s2_en    = !out_valid_reg || out_ready;
  assign s1_en    = !s1_valid_reg || s2_en;
  assign in_ready = s1_en;
  assign in_fire  = in_valid && s1_en;
  assign out_fire = out_valid_reg && out_ready;

  // --------------------------------------------------------------------
  // Injection arming
  // --------------------------------------------------------------------
  logic          inj_pend_reg;
  logic [CW-1:0] inj_mask_reg;
  logic [CW-1:0] tag_next;

  // A same-cycle arm wins over (and replaces) any previously armed mask.
  always_comb begin
    tag_next = '0;
    if (inj_arm) begin
      tag_next = inj_mask;
    end else if (inj_pend_reg) begin
      tag_next = inj_mask_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pend_reg <= 1'b0;
      inj_mask_reg <= '0;
    end else if (in_fire) begin
      inj_pend_reg <= 1'b0;
      inj_mask_reg <= '0;
    end else if (inj_arm) begin
      inj_pend_reg <= 1'b1;
      inj_mask_reg <= inj_mask;
    end
  end

  // --------------------------------------------------------------------
  // Stage 1: data, per-row per-group partial XORs, injection tag
  // --------------------------------------------------------------------
  logic [PW-1:0]       data_pad;
  logic [PAR_W*NG-1:0] part_next;
  logic [DATA_W-1:0]   s1_data_reg;
  logic [PAR_W*NG-1:0] s1_part_reg;
  logic [CW-1:0]       s1_inj_reg;
  logic [PAR_W-1:0]    par_s2;

  always_comb begin
    data_pad = '0;
    data_pad[DATA_W-1:0] = in_data;
  end

  genvar gi, gj;
  for (gi = 0; gi < PAR_W; gi++) begin : g_row
    logic [PW-1:0] row_mask;

    always_comb begin
      row_mask = '0;
      row_mask[DATA_W-1:0] = HM[gi*DATA_W +: DATA_W];
    end

    for (gj = 0; gj < NG; gj++) begin : g_grp
      dected_parity_tree #(.W(GW)) u_grp (
        .data   (data_pad[gj*GW +: GW]),
        .mask   (row_mask[gj*GW +: GW]),
        .parity (part_next[gi*NG + gj])
      );
    end

    // Stage-2 reduction of this row's partials.
    dected_parity_tree #(.W(NG)) u_red (
      .data   (s1_part_reg[gi*NG +: NG]),
      .mask   ({NG{1'b1}}),
      .parity (par_s2[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_part_reg  <= '0;
      s1_inj_reg   <= '0;
    end else if (s1_en) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg <= in_data;
        s1_part_reg <= part_next;
        s1_inj_reg  <= tag_next;
      end
    end
  end

  // --------------------------------------------------------------------
  // Stage 2: final parity, injection, output register
  // --------------------------------------------------------------------
  logic [CW-1:0] out_code_reg;
  logic [CW-1:0] code_next;

  assign code_next = {par_s2, s1_data_reg} ^ s1_inj_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_code_reg  <= '0;
    end else if (s2_en) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_code_reg <= code_next;
      end
    end
  end

  // --------------------------------------------------------------------
  // Delivered-word counter
  // --------------------------------------------------------------------
  logic [CNT_W-1:0] word_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_reg <= '0;
    end else if (out_fire) begin
      word_cnt_reg <= word_cnt_reg + 1'b1;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_code    = out_code_reg;
  assign inj_pending = inj_pend_reg;
  assign word_cnt    = word_cnt_reg;

endmodule

// File: tb/tb_dected_encoder_pipe.sv
// tb_dected_encoder_pipe
//   Directed-vector bench for dected_encoder_pipe (32-bit data, 7 parity).
module tb_dected_encoder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [38:0] out_code;
  logic        inj_arm;
  logic [38:0] inj_mask;
  logic        inj_pending;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dected_encoder_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .inj_arm     (inj_arm),
    .inj_mask    (inj_mask),
    .inj_pending (inj_pending),
    .word_cnt    (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parity rows as lists of data-bit indices (99 = unused slot).
  int hrow [7][14] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 14, 19, 22, 24, 30, 31},
    '{4, 7, 8, 9, 10, 11, 12, 13, 14, 15, 18, 21, 24, 29},
    '{3, 11, 16, 17, 18, 19, 20, 21, 22, 23, 26, 27, 29, 30},
    '{2, 6, 10, 13, 15, 16, 24, 25, 26, 27, 28, 29, 30, 31},
    '{1, 2, 5, 7, 9, 12, 15, 20, 21, 22, 23, 25, 26, 28},
    '{0, 5, 6, 8, 12, 13, 14, 16, 17, 18, 19, 20, 28, 99},
    '{0, 1, 3, 4, 8, 9, 10, 11, 17, 23, 25, 27, 31, 99}
  };

  function automatic logic [38:0] code_of(input logic [31:0] d);
    logic [6:0] p;
    p = '0;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 14; k++) begin
        if (hrow[r][k] < 32) p[r] = p[r] ^ d[hrow[r][k]];
      end
    end
    return {p, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    inj_arm   = 1'b0;
    inj_mask  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [31:0] words [4];
  int          sent;
  int          got;
  logic        accept;

  initial begin
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h0000_0001;
    words[2] = 32'hFFFF_FFFF;
    words[3] = 32'h8000_0000;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_inj_pending", inj_pending, 0);
    check("rst_in_ready", in_ready, 1);

    // ---------------- single word, latency 2 ----------------
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    tick();
    in_valid = 1'b0;
    check("lat_not_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_code", out_code, {7'h61, 32'h0000_0001});
    tick();
    check("lat_cnt", word_cnt, 1);
    check("lat_drain", out_valid, 0);

    // ---------------- back-to-back ----------------
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    tick();
    in_data = 32'h0000_0000;
    tick();
    in_valid = 1'b0;
    check("b2b_code0", out_code, {7'h60, 32'hFFFF_FFFF});
    tick();
    check("b2b_valid1", out_valid, 1);
    check("b2b_code1", out_code, {7'h00, 32'h0000_0000});
    tick();
    check("b2b_cnt", word_cnt, 2);

    // ---------------- stall during 4-word burst ----------------
    do_reset();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? words[sent] : 32'h0;
      #1;
      if (cyc == 2) check("stall_in_ready", in_ready, 0);
      if (cyc >= 2 && cyc < 5) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", out_code, code_of(words[0]));
      end
      accept = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("burst_order", out_code, code_of(words[got]));
        got++;
      end
      tick();
      if (accept) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("burst_count", got, 4);
    check("burst_cnt", word_cnt, 4);

    // ---------------- error injection ----------------
    do_reset();
    inj_arm  = 1'b1;
    inj_mask = 39'h40_0000_0001;   // bit 38 | bit 0
    tick();
    inj_arm  = 1'b0;
    inj_mask = '0;
    check("inj_armed", inj_pending, 1);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    tick();
    check("inj_consumed", inj_pending, 0);
    tick();                        // second word (same data) accepted
    in_valid = 1'b0;
    check("inj_code", out_code, {7'h21, 32'h0000_0000});
    tick();
    check("inj_next_clean", out_code, {7'h61, 32'h0000_0001});
    // arm coincident with a handshake: applies to that word, never pends
    inj_arm  = 1'b1;
    inj_mask = 39'h00_0000_0008;
    in_valid = 1'b1;
    in_data  = 32'h0000_0000;
    tick();
    inj_arm  = 1'b0;
    inj_mask = '0;
    in_valid = 1'b0;
    check("inj_same_pending", inj_pending, 0);
    tick();
    check("inj_same_code", out_code, {7'h00, 32'h0000_0008});

    // ---------------- reset mid-stream ----------------
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    inj_arm  = 1'b1;
    inj_mask = 39'h5;
    tick();
    inj_arm  = 1'b0;
    inj_mask = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_code", out_code, 0);
    check("mid_rst_cnt", word_cnt, 0);
    check("mid_rst_pending", inj_pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_no_stale", out_valid, 0);
    end
    check("mid_rst_cnt_after", word_cnt, 0);

    // ---------------- counter wrap ----------------
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("cnt_full", word_cnt, 16'hFFFF);
    in_valid = 1'b1;
    in_data  = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0;
    tick();
    check("cnt_last_code", out_code, code_of(32'hCAFE_F00D));
    tick();
    tick();
    check("cnt_wrap", word_cnt, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
